i2c_peripheral: RTL

I2C target (responder) with a byte-addressed register interface. It watches the bus pins and answers transactions for one 7-bit device address. The first written byte sets a register pointer; later bytes are written to, or read from, an external register bank with auto-increment. It is the counterpart to our I2C controller and is used as a bench partner for that controller and as on-chip target logic.

---
 rtl/i2c_peripheral_pkg.sv | 13 +
 rtl/i2c_peripheral_if.sv | 17 +
 rtl/i2c_peripheral_bus_sync.sv | 41 ++++
 rtl/i2c_peripheral.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/i2c_peripheral_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and R/W bit meaning.
package i2c_peripheral_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WR, ST_WR_ACK, ST_RD, ST_RD_ACK, ST_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic [3:0] BYTE_BITS = 4'd8;

endpackage

// File: rtl/i2c_peripheral_if.sv
// Bus pins plus register-bank port of the I2C target.
interface i2c_peripheral_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave  (input  scl_in, sda_in, reg_rdata,
                  output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy);
  modport master (output scl_in, sda_in, reg_rdata,
                  input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy);
endinterface

// File: rtl/i2c_peripheral_bus_sync.sv
// Synchronizes SCL/SDA and derives edge, START and STOP pulses.
module i2c_peripheral_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda
);
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_h, r_sda_h;
  logic                   w_scl, w_sda;

  // Idle bus is high, so reset to 1 to avoid phantom edges after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_h    <= 1'b1;
      r_sda_h    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_h    <= w_scl;
      r_sda_h    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign o_scl_rise = w_scl & ~r_scl_h;
  assign o_scl_fall = ~w_scl & r_scl_h;
  assign o_start    = w_scl & r_scl_h & r_sda_h & ~w_sda;
  assign o_stop     = w_scl & r_scl_h & ~r_sda_h & w_sda;
  assign o_sda      = w_sda;
endmodule

// File: rtl/i2c_peripheral.sv
// I2C target with an 8-bit register pointer and auto-incrementing register bank access.
module i2c_peripheral
  import i2c_peripheral_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  i2c_peripheral_if.slave  bus
);
  logic       w_rise, w_fall, w_start, w_stop, w_sda, w_match;
  logic [7:0] w_shift_in;

  i2c_state_e r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_addr, w_addr_nxt;
  logic [7:0] r_wdata, w_wdata_nxt;
  logic       r_we, w_we_nxt;
  logic       r_re_req, w_re_req_nxt;
  logic       r_re;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_busy, w_busy_nxt;

  i2c_peripheral_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .i_scl(bus.scl_in), .i_sda(bus.sda_in),
    .o_scl_rise(w_rise), .o_scl_fall(w_fall), .o_start(w_start),
    .o_stop(w_stop), .o_sda(w_sda)
  );

  assign w_shift_in = {r_shift[6:0], w_sda};
  // Address 0 (general call) never matches.
  assign w_match    = (r_shift[7:1] == DEVICE_ADDR) && (r_shift[7:1] != 7'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop)       w_state_nxt = ST_IDLE;
    else if (w_start) w_state_nxt = ST_ADDR;
    else begin
      case (r_state)
        ST_ADDR:     if (w_fall && r_cnt == BYTE_BITS)
                       w_state_nxt = w_match ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK: if (w_rise && r_shift[0] == I2C_RW_READ)       w_state_nxt = ST_RD;
                     else if (w_fall && r_shift[0] == I2C_RW_WRITE) w_state_nxt = ST_PTR;
        ST_PTR:      if (w_fall && r_cnt == BYTE_BITS) w_state_nxt = ST_PTR_ACK;
        ST_PTR_ACK,
        ST_WR_ACK:   if (w_fall) w_state_nxt = ST_WR;
        ST_WR:       if (w_fall && r_cnt == BYTE_BITS) w_state_nxt = ST_WR_ACK;
        ST_RD:       if (w_fall && r_cnt == BYTE_BITS) w_state_nxt = ST_RD_ACK;
        ST_RD_ACK:   if (w_rise) w_state_nxt = w_sda ? ST_WAIT_STOP : ST_RD;
        default:     ;
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_we_nxt     = 1'b0;
    w_re_req_nxt = 1'b0;
    w_sda_oe_nxt = r_sda_oe;
    w_busy_nxt   = r_busy;
    if (r_we) w_addr_nxt = r_addr + 8'd1;
    if (r_re) w_shift_nxt = bus.reg_rdata;
    if (w_stop) begin
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_cnt_nxt    = '0;
    end else if (w_start) begin
      w_sda_oe_nxt = 1'b0;
      w_cnt_nxt    = '0;
    end else begin
      if (w_rise && r_cnt < BYTE_BITS) begin
        if (r_state inside {ST_ADDR, ST_PTR, ST_WR}) begin
          w_shift_nxt = w_shift_in;
          w_cnt_nxt   = r_cnt + 4'd1;
        end else if (r_state == ST_RD) begin
          w_shift_nxt = {r_shift[6:0], 1'b0};
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      case (r_state)
        ST_ADDR:     if (w_fall && r_cnt == BYTE_BITS) begin
                       w_sda_oe_nxt = w_match;
                       w_busy_nxt   = w_match;
                     end
        ST_ADDR_ACK: if (w_rise && r_shift[0] == I2C_RW_READ) w_re_req_nxt = 1'b1;
                     else if (w_fall) w_sda_oe_nxt = 1'b0;
        ST_PTR:      if (w_fall && r_cnt == BYTE_BITS) begin
                       w_addr_nxt   = r_shift;
                       w_sda_oe_nxt = 1'b1;
                     end
        ST_WR: begin
          if (w_rise && r_cnt == BYTE_BITS - 4'd1) begin
            w_we_nxt    = 1'b1;
            w_wdata_nxt = w_shift_in;
          end
          if (w_fall && r_cnt == BYTE_BITS) w_sda_oe_nxt = 1'b1;
        end
        ST_PTR_ACK,
        ST_WR_ACK:   if (w_fall) w_sda_oe_nxt = 1'b0;
        // First fall in RD also ends the preceding ACK drive.
        ST_RD:       if (w_fall) w_sda_oe_nxt = (r_cnt == BYTE_BITS) ? 1'b0 : ~r_shift[7];
        ST_RD_ACK:   if (w_rise && !w_sda) begin
                       w_addr_nxt   = r_addr + 8'd1;
                       w_re_req_nxt = 1'b1;
                     end
        default:     ;
      endcase
      if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end
  end

  // reg_re trails the pointer update by a cycle so reg_rdata reflects the new address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_re_req <= 1'b0;
      r_re     <= 1'b0;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_we     <= w_we_nxt;
      r_re_req <= w_re_req_nxt;
      r_re     <= r_re_req;
      r_sda_oe <= w_sda_oe_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign bus.sda_oe    = r_sda_oe;
  assign bus.reg_addr  = r_addr;
  assign bus.reg_wdata = r_wdata;
  assign bus.reg_we    = r_we;
  assign bus.reg_re    = r_re;
  assign bus.busy      = r_busy;
endmodule
